fetch_unit: RTL and testbench

- Instruction fetch stage of the 16-bit single-cycle RISC core; sits directly upstream of decode/sign_extend.
- Holds the PC and requests instruction words from instruction memory over a req/ack handshake.
- Presents each fetched word to decode over a valid/ready handshake.
- Consumes the 16-bit sign-extended branch offset produced downstream to compute the next PC.

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack and hands them
// to decode over valid/ready, computing the next PC from jump/branch info on accept.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic [15:0] instr_o,
    output logic [15:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [15:0] jump_target_i,
    output logic [15:0] instr_count_o
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic [15:0] count_q, count_d;
    logic        valid_q, valid_d;
    logic        accept;
    logic [15:0] next_pc;

    assign accept = valid_q & instr_ready_i;

    // Jump wins over a taken branch; all arithmetic wraps mod 2^16.
    always_comb begin
        if (jump_i) begin
            next_pc = jump_target_i;
        end else if (branch_taken_i) begin
            next_pc = instr_pc_q + 16'd1 + branch_offset_i;
        end else begin
            next_pc = instr_pc_q + 16'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        count_d    = count_q;
        valid_d    = valid_q;
        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack_i) begin
                    instr_d    = imem_data_i;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (accept) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    pc_d    = next_pc;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= 16'h0000;
            instr_pc_q <= 16'h0000;
            count_q    <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
        end
    end

    // Request decodes straight from state so an async reset drops it at once.
    assign imem_req_o    = (state_q == StFetch);
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetches push expected accepts and
// request addresses; a negedge monitor pops and compares them.
module tb_fetch_unit;

    logic        clk_i;
    logic        rst_n_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;
    logic [15:0] instr_o;
    logic [15:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        branch_taken_i;
    logic [15:0] branch_offset_i;
    logic        jump_i;
    logic [15:0] jump_target_i;
    logic [15:0] instr_count_o;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .branch_taken_i (branch_taken_i),
        .branch_offset_i(branch_offset_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .instr_count_o  (instr_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_instr_q[$];   // {instr, pc} expected at each accept
    logic [15:0] exp_addr_q[$];    // address expected at each new request
    logic [15:0] exp_count = 16'h0000;
    logic        req_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: compares accepted instructions and the address of each new request.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            req_prev <= 1'b0;
        end else begin
            if (instr_valid_o && instr_ready_i) begin
                if (exp_instr_q.size() == 0) fail("unexpected_accept");
                else check("accept_instr_pc", {instr_o, instr_pc_o}, exp_instr_q.pop_front());
            end
            if (imem_req_o && !req_prev) begin
                if (exp_addr_q.size() == 0) fail("unexpected_req");
                else check("req_addr", {16'h0, imem_addr_o}, {16'h0, exp_addr_q.pop_front()});
            end
            req_prev <= imem_req_o;
        end
    end

    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!imem_req_o) fail("req_timeout");
    endtask

    task automatic do_instr(input logic [15:0] data, input int waits, input int stall,
                            input logic br, input logic [15:0] off, input logic jmp,
                            input logic [15:0] tgt, input logic [15:0] exp_pc,
                            input logic [15:0] exp_next);
        exp_instr_q.push_back({data, exp_pc});
        exp_addr_q.push_back(exp_next);
        wait_req();
        for (int i = 0; i < waits; i++) begin
            @(posedge clk_i);
            #1;
            check("fetch_wait_req", {31'h0, imem_req_o}, 32'h1);
            check("fetch_wait_addr", {16'h0, imem_addr_o}, {16'h0, exp_pc});
        end
        imem_ack_i  = 1'b1;
        imem_data_i = data;
        @(posedge clk_i);
        #1;
        imem_ack_i = 1'b0;
        check("hold_valid", {31'h0, instr_valid_o}, 32'h1);
        check("hold_instr", {instr_o, instr_pc_o}, {data, exp_pc});
        check("hold_no_req", {31'h0, imem_req_o}, 32'h0);
        // Stall with ack pulses and flow-control noise that must all be ignored.
        for (int i = 0; i < stall; i++) begin
            imem_ack_i      = 1'b1;
            imem_data_i     = 16'hDEAD;
            jump_i          = 1'b1;
            jump_target_i   = 16'h0BAD;
            branch_taken_i  = 1'b1;
            branch_offset_i = 16'h0777;
            @(posedge clk_i);
            #1;
            check("stall_valid", {31'h0, instr_valid_o}, 32'h1);
            check("stall_instr", {instr_o, instr_pc_o}, {data, exp_pc});
            check("stall_no_req", {31'h0, imem_req_o}, 32'h0);
        end
        imem_ack_i      = 1'b0;
        instr_ready_i   = 1'b1;
        branch_taken_i  = br;
        branch_offset_i = off;
        jump_i          = jmp;
        jump_target_i   = tgt;
        @(posedge clk_i);
        #1;
        instr_ready_i   = 1'b0;
        branch_taken_i  = 1'b0;
        branch_offset_i = 16'h0;
        jump_i          = 1'b0;
        jump_target_i   = 16'h0;
        exp_count       = exp_count + 16'd1;
        check("count", {16'h0, instr_count_o}, {16'h0, exp_count});
        check("post_accept_valid", {31'h0, instr_valid_o}, 32'h0);
        check("post_accept_req", {31'h0, imem_req_o}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i         = 1'b0;
        imem_ack_i      = 1'b0;
        imem_data_i     = 16'h0;
        instr_ready_i   = 1'b0;
        branch_taken_i  = 1'b0;
        branch_offset_i = 16'h0;
        jump_i          = 1'b0;
        jump_target_i   = 16'h0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req", {31'h0, imem_req_o}, 32'h0);
        check("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        check("rst_instr", {instr_o, instr_pc_o}, 32'h0);
        check("rst_count", {16'h0, instr_count_o}, 32'h0);
        check("rst_addr", {16'h0, imem_addr_o}, 32'h0);
        exp_addr_q.push_back(16'h0000);
        rst_n_i = 1'b1;
        check("idle_no_req", {31'h0, imem_req_o}, 32'h0);
        @(posedge clk_i);
        #1;
        check("first_req", {31'h0, imem_req_o}, 32'h1);

        //       data      w  s  br    off       jmp   tgt       pc        next
        do_instr(16'h1234, 3, 0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0001);
        do_instr(16'hBEEF, 0, 5, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001, 16'h0002);
        do_instr(16'h1111, 1, 0, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h0002, 16'h0010);
        do_instr(16'h2222, 0, 1, 1'b1, 16'hFFFC, 1'b0, 16'h0000, 16'h0010, 16'h000D);
        do_instr(16'h3333, 2, 0, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h000D, 16'h0010);
        do_instr(16'h4444, 0, 0, 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0010, 16'h0016);
        do_instr(16'h5555, 1, 2, 1'b1, 16'h0005, 1'b1, 16'h0100, 16'h0016, 16'h0100);
        do_instr(16'h6666, 0, 0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0100, 16'hFFFF);
        do_instr(16'h7777, 0, 0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 16'h0000);

        // Reset in the middle of a fetch at pc 0x0000.
        wait_req();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        check("midrst_req", {31'h0, imem_req_o}, 32'h0);
        check("midrst_valid", {31'h0, instr_valid_o}, 32'h0);
        check("midrst_instr", {instr_o, instr_pc_o}, 32'h0);
        check("midrst_count", {16'h0, instr_count_o}, 32'h0);
        exp_count = 16'h0000;
        exp_addr_q.push_back(16'h0000);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        check("midrst_idle", {31'h0, imem_req_o}, 32'h0);
        do_instr(16'h5A5A, 1, 0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0001);

        repeat (3) @(posedge clk_i);
        #1;
        check("instr_q_drained", exp_instr_q.size(), 32'h0);
        check("addr_q_drained", exp_addr_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
